pll_reconfig_ctrl: RTL and testbench

- Sequencer that drives the dynamic divider-select inputs of a Gowin rPLL (DYN_IDIV_SEL/DYN_FBDIV_SEL/DYN_ODIV_SEL = "true").
- Applies new divider settings on request and performs the PLL reset pulse.
- Waits for lock with timeout, retry and stability qualification, then reports success or failure.
- Sits beside the rPLL wrapper. Lets the PSRAM clock be retuned at runtime instead of being fixed at build time.

---
 rtl/pll_reconfig_pkg.sv | 25 ++
 rtl/pll_reconfig_ctrl_if.sv | 23 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_reconfig_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared types and helpers for the rPLL reconfiguration sequencer.
package pll_reconfig_pkg;

    localparam int unsigned DivW     = 6;
    localparam int unsigned AttemptW = 4;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StWaitLock,
        StStable,
        StReady
    } state_e;

    // Width of a counter that runs 0 .. max_val-1.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

    // rPLL IDSEL/FBDSEL take the bitwise complement of the divide-minus-one value.
    function automatic logic [DivW-1:0] div_code(input logic [DivW-1:0] div);
        return ~div;
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// Request/completion handshake between a PLL retune client and pll_reconfig_ctrl.
interface pll_reconfig_ctrl_if;
    import pll_reconfig_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [DivW-1:0] req_idiv;
    logic [DivW-1:0] req_fbdiv;
    logic [DivW-1:0] req_odsel;
    logic            done_valid;
    logic            done_err;

    modport master (
        output req_valid, req_idiv, req_fbdiv, req_odsel,
        input  req_ready, done_valid, done_err
    );

    modport slave (
        input  req_valid, req_idiv, req_fbdiv, req_odsel,
        output req_ready, done_valid, done_err
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level signals; flops clear on rst.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Applies divider settings to a Gowin rPLL, pulses its reset and qualifies lock with retries.
// Define PLL_AUTO_RELOCK_EN to restart the sequence automatically when lock drops in READY.
module pll_reconfig_ctrl
    import pll_reconfig_pkg::*;
#(
    parameter logic [DivW-1:0] DEF_IDIV      = 6'd0,
    parameter logic [DivW-1:0] DEF_FBDIV     = 6'd1,
    parameter logic [DivW-1:0] DEF_ODSEL     = 6'd8,
    parameter int unsigned     RESET_CYCLES  = 16,
    parameter int unsigned     LOCK_TIMEOUT  = 4096,
    parameter int unsigned     STABLE_CYCLES = 256,
    parameter int unsigned     MAX_RETRY     = 3
) (
    input  logic                clk,
    input  logic                rst,
    pll_reconfig_ctrl_if.slave  req_if,
    output logic [DivW-1:0]     pll_idsel,
    output logic [DivW-1:0]     pll_fbdsel,
    output logic [DivW-1:0]     pll_odsel,
    output logic                pll_reset,
    input  logic                pll_lock,
    output logic                locked,
    output logic                lock_lost,
    output logic [AttemptW-1:0] attempts
);

    localparam int unsigned RstW  = cnt_width(RESET_CYCLES);
    localparam int unsigned ToW   = cnt_width(LOCK_TIMEOUT);
    localparam int unsigned StabW = cnt_width(STABLE_CYCLES);
    localparam logic [4:0]  MaxTry = 5'(MAX_RETRY);

    state_e          state_q, state_d;
    logic [DivW-1:0] idiv_q, idiv_d, fbdiv_q, fbdiv_d, odsel_q, odsel_d;
    logic            pll_reset_q, pll_reset_d;
    logic            locked_q, locked_d;
    logic            done_valid_q, done_valid_d, done_err_q, done_err_d;
    logic            lock_lost_q, lock_lost_d;
    logic [4:0]      tries_q, tries_d;  // one bit wider than attempts so MAX_RETRY=15 terminates
    logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic [StabW-1:0] stab_cnt_q, stab_cnt_d;
    logic            lock_s;
    logic            accept;

    sync_2ff #(
        .Width (1)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_lock),
        .q_o (lock_s)
    );

    assign req_if.req_ready = (state_q == StIdle) || (state_q == StReady);
    assign accept           = req_if.req_valid && req_if.req_ready;

    always_comb begin
        state_d      = state_q;
        idiv_d       = idiv_q;
        fbdiv_d      = fbdiv_q;
        odsel_d      = odsel_q;
        pll_reset_d  = pll_reset_q;
        locked_d     = locked_q;
        done_valid_d = 1'b0;
        done_err_d   = 1'b0;
        lock_lost_d  = 1'b0;
        tries_d      = tries_q;
        rst_cnt_d    = rst_cnt_q;
        to_cnt_d     = to_cnt_q;
        stab_cnt_d   = stab_cnt_q;

        unique case (state_q)
            StIdle: ;
            StApply: begin
                to_cnt_d   = '0;
                stab_cnt_d = '0;
                if (rst_cnt_q == '0) tries_d = tries_q + 5'd1;
                if (rst_cnt_q == RstW'(RESET_CYCLES - 1)) begin
                    rst_cnt_d   = '0;
                    pll_reset_d = 1'b0;
                    state_d     = StWaitLock;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            StWaitLock, StStable: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // Qualification completing on the timeout cycle still counts as success.
                if (lock_s && (stab_cnt_q == StabW'(STABLE_CYCLES - 1))) begin
                    done_valid_d = 1'b1;
                    locked_d     = 1'b1;
                    state_d      = StReady;
                end else if (to_cnt_q == ToW'(LOCK_TIMEOUT - 1)) begin
                    if (tries_q <= MaxTry) begin
                        pll_reset_d = 1'b1;
                        state_d     = StApply;
                    end else begin
                        done_valid_d = 1'b1;
                        done_err_d   = 1'b1;
                        locked_d     = 1'b0;
                        state_d      = StIdle;
                    end
                end else if (lock_s) begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                    state_d    = StStable;
                end else begin
                    stab_cnt_d = '0;
                    state_d    = StWaitLock;
                end
            end
            StReady: begin
                if (!lock_s) begin
                    lock_lost_d = 1'b1;
                    locked_d    = 1'b0;
`ifdef PLL_AUTO_RELOCK_EN
                    tries_d     = '0;
                    rst_cnt_d   = '0;
                    pll_reset_d = 1'b1;
                    state_d     = StApply;
`else
                    state_d     = StIdle;
`endif
                end
            end
            default: state_d = StApply;
        endcase

        // A request beats a simultaneous lock loss, but lock_lost still pulses.
        if (accept) begin
            idiv_d      = req_if.req_idiv;
            fbdiv_d     = req_if.req_fbdiv;
            odsel_d     = req_if.req_odsel;
            tries_d     = '0;
            locked_d    = 1'b0;
            rst_cnt_d   = '0;
            pll_reset_d = 1'b1;
            state_d     = StApply;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StApply;
            idiv_q       <= DEF_IDIV;
            fbdiv_q      <= DEF_FBDIV;
            odsel_q      <= DEF_ODSEL;
            pll_reset_q  <= 1'b1;
            locked_q     <= 1'b0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            lock_lost_q  <= 1'b0;
            tries_q      <= '0;
            rst_cnt_q    <= '0;
            to_cnt_q     <= '0;
            stab_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            idiv_q       <= idiv_d;
            fbdiv_q      <= fbdiv_d;
            odsel_q      <= odsel_d;
            pll_reset_q  <= pll_reset_d;
            locked_q     <= locked_d;
            done_valid_q <= done_valid_d;
            done_err_q   <= done_err_d;
            lock_lost_q  <= lock_lost_d;
            tries_q      <= tries_d;
            rst_cnt_q    <= rst_cnt_d;
            to_cnt_q     <= to_cnt_d;
            stab_cnt_q   <= stab_cnt_d;
        end
    end

    assign pll_idsel         = div_code(idiv_q);
    assign pll_fbdsel        = div_code(fbdiv_q);
    assign pll_odsel         = odsel_q;
    assign pll_reset         = pll_reset_q;
    assign locked            = locked_q;
    assign lock_lost         = lock_lost_q;
    assign req_if.done_valid = done_valid_q;
    assign req_if.done_err   = done_err_q;
    assign attempts          = tries_q[4] ? 4'hF : tries_q[3:0];

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench for pll_reconfig_ctrl: a PLL model drives lock, a monitor checks each done event.
module tb_pll_reconfig_ctrl;

    localparam int RC   = 4;
    localparam int LT   = 32;
    localparam int SC   = 8;
    localparam int MR   = 2;
    localparam int NONE = 1000;

    typedef struct {
        logic       err;
        int         att;
        logic [5:0] ids;
        logic [5:0] fbs;
        logic [5:0] ods;
        int         off;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       pll_reset, locked, lock_lost;
    logic [3:0] attempts;

    pll_reconfig_ctrl_if bus ();

    pll_reconfig_ctrl #(
        .DEF_IDIV      (6'd0),
        .DEF_FBDIV     (6'd1),
        .DEF_ODSEL     (6'd8),
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRY     (MR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_if     (bus.slave),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .pll_reset  (pll_reset),
        .pll_lock   (pll_lock),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .attempts   (attempts)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    int   plan_rise[MR+1];
    int   plan_glitch[MR+1];
    int   plan_gen = 0;
    bit   lost = 1'b0;
    logic [5:0] last_id, last_fb, last_od;

    function automatic void chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Offset (samples after reset release) at which SC consecutive synced-high samples are complete.
    function automatic int settle(input int r, input int g);
        int run = 0;
        for (int k = 0; k < LT + SC + 8; k++) begin
            if ((k - 2 >= r) && (k - 2 != g)) run++;
            else run = 0;
            if (run == SC) return k + 1;
        end
        return NONE;
    endfunction

    function automatic exp_t predict(input logic [5:0] idv, input logic [5:0] fbv,
                                     input logic [5:0] odv);
        exp_t e;
        e.ids = ~idv;
        e.fbs = ~fbv;
        e.ods = odv;
        e.err = 1'b1;
        e.att = MR + 1;
        e.off = LT;
        for (int a = 0; a <= MR; a++) begin
            int d = settle(plan_rise[a], plan_glitch[a]);
            if (d <= LT) begin
                e.err = 1'b0;
                e.att = a + 1;
                e.off = d;
                return e;
            end
        end
        return e;
    endfunction

    // PLL model: lock follows the plan for the current attempt, measured from reset release.
    int m_off = 0, m_att = 0, m_seen = -1, m_r = NONE, m_g = NONE;
    bit m_in_rst = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (pll_reset) begin
                m_in_rst = 1'b1;
                pll_lock = 1'b0;
            end else begin
                if (m_in_rst) begin
                    m_in_rst = 1'b0;
                    m_off    = 0;
                    if (m_seen != plan_gen) begin
                        m_seen = plan_gen;
                        m_att  = 0;
                    end else begin
                        m_att++;
                    end
                    m_r = (m_att <= MR) ? plan_rise[m_att] : NONE;
                    m_g = (m_att <= MR) ? plan_glitch[m_att] : NONE;
                end else begin
                    m_off++;
                end
                pll_lock = !lost && (m_off >= m_r) && (m_off != m_g);
            end
        end
    end

    // Monitor: checks reset pulse widths and every done event against the scoreboard.
    int   mon_off = 0, hi_run = 0, pulses = 0;
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                mon_off = 0;
                hi_run  = 0;
                pulses  = 0;
            end else begin
                if (pll_reset) begin
                    hi_run++;
                end else begin
                    if (hi_run != 0) begin
                        chk("reset_width", hi_run, RC);
                        pulses++;
                        mon_off = 0;
                    end else begin
                        mon_off++;
                    end
                    hi_run = 0;
                end
                if (bus.done_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", int'(bus.done_valid), 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("done_err", int'(bus.done_err), int'(mon_e.err));
                        chk("attempts", int'(attempts), mon_e.att);
                        chk("apply_pulses", pulses, mon_e.att);
                        chk("locked_at_done", int'(locked), int'(!mon_e.err));
                        chk("idsel", int'(pll_idsel), int'(mon_e.ids));
                        chk("fbdsel", int'(pll_fbdsel), int'(mon_e.fbs));
                        chk("odsel", int'(pll_odsel), int'(mon_e.ods));
                        chk("done_time", mon_off, mon_e.off);
                        pulses = 0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fixed_plan(input int r, input int g);
        for (int a = 0; a <= MR; a++) begin
            plan_rise[a]   = (a == 0) ? r : NONE;
            plan_glitch[a] = (a == 0) ? g : NONE;
        end
        plan_gen++;
    endtask

    task automatic rand_plan();
        for (int a = 0; a <= MR; a++) begin
            int k = int'($urandom_range(0, 3));
            plan_rise[a]   = (k == 0) ? NONE : int'($urandom_range(0, 26));
            plan_glitch[a] = ($urandom_range(0, 1) == 1) ?
                             plan_rise[a] + int'($urandom_range(1, 8)) : NONE;
        end
        plan_gen++;
    endtask

    task automatic do_req(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
        int n = 0;
        logic [5:0] inv;
        while (!bus.req_ready && n < 200) begin
            tick();
            n++;
        end
        chk("req_ready_before_req", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_idiv  = id;
        bus.req_fbdiv = fb;
        bus.req_odsel = od;
        last_id = id;
        last_fb = fb;
        last_od = od;
        exp_q.push_back(predict(id, fb, od));
        tick();
        bus.req_valid = 1'b0;
        inv = ~id;
        chk("accept_idsel", int'(pll_idsel), int'(inv));
        inv = ~fb;
        chk("accept_fbdsel", int'(pll_fbdsel), int'(inv));
        chk("accept_odsel", int'(pll_odsel), int'(od));
        chk("accept_pll_reset", int'(pll_reset), 1);
        chk("accept_req_ready", int'(bus.req_ready), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        bit stall_bad = 1'b0;
        while (exp_q.size() != 0 && n < 600) begin
            if (!bus.done_valid && bus.req_ready) stall_bad = 1'b1;
            tick();
            n++;
        end
        chk("done_arrived", exp_q.size(), 0);
        chk("ready_low_in_sequence", int'(stall_bad), 0);
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_idiv  = '0;
        bus.req_fbdiv = '0;
        bus.req_odsel = '0;
        rst = 1'b1;
        fixed_plan(10, NONE);
        repeat (4) tick();
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_done_valid", int'(bus.done_valid), 0);
        chk("rst_done_err", int'(bus.done_err), 0);
        chk("rst_lock_lost", int'(lock_lost), 0);
        chk("rst_attempts", int'(attempts), 0);
        chk("rst_pll_reset", int'(pll_reset), 1);
        chk("rst_idsel", int'(pll_idsel), 'h3F);
        chk("rst_fbdsel", int'(pll_fbdsel), 'h3E);
        chk("rst_odsel", int'(pll_odsel), 8);

        // Boot sequence with default settings.
        rst = 1'b0;
        exp_q.push_back(predict(6'd0, 6'd1, 6'd8));
        wait_done();
        chk("boot_locked", int'(locked), 1);
        chk("boot_ready", int'(bus.req_ready), 1);
        chk("boot_attempts", int'(attempts), 1);

        // Directed request from READY.
        fixed_plan(5, NONE);
        do_req(6'd2, 6'd9, 6'd4);
        wait_done();

        // Lock never rises: all attempts time out.
        fixed_plan(NONE, NONE);
        do_req(6'($urandom), 6'($urandom), 6'($urandom));
        wait_done();
        chk("fail_ready", int'(bus.req_ready), 1);
        chk("fail_locked", int'(locked), 0);
        chk("fail_attempts", int'(attempts), MR + 1);

        // One-cycle glitch during qualification.
        fixed_plan(3, 8);
        do_req(6'($urandom), 6'($urandom), 6'($urandom));
        wait_done();

        for (int i = 0; i < 25; i++) begin
            rand_plan();
            do_req(6'($urandom), 6'($urandom), 6'($urandom));
            wait_done();
        end

        // Lock loss in READY.
        fixed_plan(2, NONE);
        do_req(6'($urandom), 6'($urandom), 6'($urandom));
        wait_done();
`ifdef PLL_AUTO_RELOCK_EN
        fixed_plan(4, NONE);
        exp_q.push_back(predict(last_id, last_fb, last_od));
`endif
        lost = 1'b1;
        n = 0;
        while (!lock_lost && n < 10) begin
            tick();
            n++;
        end
        chk("lock_lost_seen", int'(lock_lost), 1);
        chk("lost_locked", int'(locked), 0);
`ifdef PLL_AUTO_RELOCK_EN
        chk("relock_pll_reset", int'(pll_reset), 1);
        tick();
        chk("lock_lost_single", int'(lock_lost), 0);
        lost = 1'b0;
        wait_done();
        chk("relock_locked", int'(locked), 1);
`else
        chk("lost_pll_reset", int'(pll_reset), 0);
        tick();
        chk("lock_lost_single", int'(lock_lost), 0);
        repeat (5) tick();
        chk("lost_idle_ready", int'(bus.req_ready), 1);
        chk("lost_idle_pll_reset", int'(pll_reset), 0);
        chk("lost_odsel_kept", int'(pll_odsel), int'(last_od));
        lost = 1'b0;
`endif

        // rst during WAIT_LOCK aborts and reruns boot.
        fixed_plan(NONE, NONE);
        do_req(6'd5, 6'd7, 6'd3);
        n = 0;
        while (pll_reset && n < 20) begin
            tick();
            n++;
        end
        repeat (5) tick();
        rst = 1'b1;
        fixed_plan(10, NONE);
        repeat (3) tick();
        chk("abort_idsel", int'(pll_idsel), 'h3F);
        chk("abort_fbdsel", int'(pll_fbdsel), 'h3E);
        chk("abort_odsel", int'(pll_odsel), 8);
        chk("abort_done_valid", int'(bus.done_valid), 0);
        rst = 1'b0;
        exp_q.push_back(predict(6'd0, 6'd1, 6'd8));
        wait_done();
        chk("reboot_locked", int'(locked), 1);
        chk("reboot_attempts", int'(attempts), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
